// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Acknowledges UART receive flags and buffers bytes in a FWFT FIFO.
//  Option   : UART_RX_FIFO_PARITY_TAG_EN stores the parity-error tag per entry.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] rx_data,
    input  logic                   rx_flag,
    input  logic                   rx_parity_err,
    output logic                   clear_rx_flag,
    input  logic                   rd_en,
    output logic [WORD_LENGTH-1:0] rd_data,
    output logic                   rd_parity_err,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

`ifdef UART_RX_FIFO_PARITY_TAG_EN
    localparam int c_ENTRY_W = WORD_LENGTH + 1;
`else
    localparam int c_ENTRY_W = WORD_LENGTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLEAR    = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_clear;
    logic                    w_clear_nxt;
    logic [c_ENTRY_W-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_overflow;
    logic                    w_capture;
    logic                    w_wr_req;
    logic                    w_wr_ok;
    logic                    w_drop;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [c_ENTRY_W-1:0]    w_wr_word;
    logic [c_ENTRY_W-1:0]    w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_clear_nxt = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_flag) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CLEAR;
                    w_clear_nxt = 1'b1;
                end
            end
            S_CLEAR:    w_state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!rx_flag) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clear <= w_clear_nxt;
        end
    end

`ifdef UART_RX_FIFO_PARITY_TAG_EN
    assign w_wr_word     = {rx_parity_err, rx_data};
    assign w_wr_req      = w_capture;
    assign rd_parity_err = w_head[WORD_LENGTH];
`else
    // Without a tag slot, corrupted bytes are acknowledged but never stored.
    assign w_wr_word     = rx_data;
    assign w_wr_req      = w_capture & ~rx_parity_err;
    assign rd_parity_err = 1'b0;
`endif

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en & ~w_empty;
    // A full FIFO still takes a byte when the head is popped in the same cycle.
    assign w_wr_ok = w_wr_req & (~w_full | w_pop);
    assign w_drop  = w_wr_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rd_data       = w_head[WORD_LENGTH-1:0];
    assign clear_rx_flag = r_clear;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each completed byte on RX_FLAG and pulses Clear_RX_Flag back to the receiver to acknowledge it.
- Stores bytes in a first-word-fall-through FIFO so the host logic can read them at its own pace without losing back-to-back frames (frames arrive every ~176 clocks at 16 clocks/bit).

Parameters:
- WORD_LENGTH, 8, width of received data word (matches UART DATARX).
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, same clock as UART.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  WORD_LENGTH  byte from UART DATARX.
- rx_flag  input  1  UART RX_FLAG; level, high while a received byte is pending.
- rx_parity_err  input  1  UART ParityError, valid while rx_flag is high.
- clear_rx_flag  output  1  to UART Clear_RX_Flag; one-cycle acknowledge pulse.
- rd_en  input  1  pop request; ignored when empty.
- rd_data  output  WORD_LENGTH  head-of-FIFO word; valid when empty=0.
- rd_parity_err  output  1  parity tag of head word (see Optional Feature).
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, clear_rx_flag=0, FSM=IDLE. Memory contents are not reset.
- Capture FSM, three states; clear_rx_flag is a registered Moore output, high only in CLEAR.
  - IDLE: on rx_flag=1, sample rx_data/rx_parity_err at that edge, perform write, go to CLEAR. Otherwise stay.
  - CLEAR: clear_rx_flag=1 for exactly one cycle; go to WAIT_LOW unconditionally.
  - WAIT_LOW: stay while rx_flag=1; go to IDLE when rx_flag=0. Prevents a second capture of the same byte during the UART's clear latency.
- Write rule: a write is accepted if full=0, or if full=1 and a pop happens in the same cycle.
  - If the write is rejected: byte discarded, overflow set to 1, FSM still proceeds to CLEAR so the UART is acknowledged.
- Read rule: rd_data/rd_parity_err continuously show mem[rd_ptr] (FWFT).
  - rd_en=1 with empty=0 advances rd_ptr on the clock edge.
  - rd_en=1 with empty=1 has no effect.
- Simultaneous write and pop: both pointers advance; count unchanged.
- Pointer wrap: pointers wrap modulo DEPTH.
- Flag derivation: count is an explicit up/down counter; empty=(count==0), full=(count==DEPTH), both registered-consistent with count.
- Write latency: byte visible on rd_data, with empty=0, one cycle after the capture edge.
- Overflow priority: clr_overflow=1 clears overflow; if an overflow drop occurs in the same cycle, set wins.
- Reset mid-operation: immediate return to reset state; a pending rx_flag is captured after reset release as a new byte.

Optional Feature:
- Macro UART_RX_FIFO_PARITY_TAG_EN.
- Defined: each entry is WORD_LENGTH+1 bits wide, storing rx_parity_err alongside the data; rd_parity_err shows the head entry's tag. Bytes with parity errors are stored normally.
- Undefined: entries are WORD_LENGTH bits and rd_parity_err is tied to 0. A byte with rx_parity_err=1 is not written; it is still acknowledged (CLEAR pulse), and overflow is not affected.

Test Plan:
- Reset, then rx_data=8'h05, rx_flag=1 held 3 cycles, dropped after clear_rx_flag -> exactly one clear_rx_flag pulse; next cycle empty=0, count=1, rd_data=8'h05.
- Write 8 bytes 8'h10..8'h17 via rx_flag handshakes, no reads -> full=1, count=8. Send 9th byte 8'hAA -> clear_rx_flag still pulses, overflow=1, count=8. Pop 8 times -> data 8'h10..8'h17 in order, then empty=1.
- FIFO full, byte 8'h55 arrives in the same cycle rd_en=1 -> write accepted, count stays 8, overflow=0; after 8 pops the last word read is 8'h55.
- Write 12 and read 12 interleaved -> pointers wrap, order preserved, count never exceeds 8, empty=1 at end.
- With overflow=1, assert clr_overflow for one cycle -> overflow=0. Assert reset=0 mid-CLEAR -> clear_rx_flag=0, count=0, empty=1 immediately.
- Byte 8'h3C with rx_parity_err=1 -> with UART_RX_FIFO_PARITY_TAG_EN: stored, rd_parity_err=1. Without it: acknowledged, not stored, empty stays 1.
